// File: rtl/tqv_bus_pkg.sv
// tqv_bus_pkg: size encodings, FSM states and command helpers for the TinyQV bus initiator
package tqv_bus_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;
  typedef enum logic [2:0] {IDLE, WRITE, READ, COMPLETE, RESP} state_t;
  function automatic logic [31:0] size_mask(input logic [1:0] size);
    return size == SZ_BYTE ? 32'h0000_00ff : size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff;
  endfunction
  function automatic logic bad_cmd(input logic [1:0] size, input logic [1:0] low);
    return size == SZ_NONE || (size == SZ_HALF && low[0]) || (size == SZ_WORD && low != 2'b00);
  endfunction
endpackage

// File: rtl/tqv_bus_timeout.sv
// tqv_bus_timeout: loadable down-counter whose expiry flag bounds a bus wait
module tqv_bus_timeout #(
  parameter int CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  logic [15:0] count;
  assign expired = count == '0;
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (load) count <= 16'(CYCLES - 1);
    else if (en && !expired) count <= count - 16'd1;
  end
endmodule

// File: rtl/tqv_bus_initiator.sv
// tqv_bus_initiator: valid/ready command stream to TinyQV peripheral bus master.
// Define TQV_BUS_INIT_TIMEOUT_EN to abort transactions that never see data_ready.
module tqv_bus_initiator
  import tqv_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_size,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] addr_out,
  output logic [31:0]       data_out,
  output logic [1:0]        data_write_n,
  output logic [1:0]        data_read_n,
  input  logic [31:0]       data_in,
  input  logic              data_ready,
  output logic              data_read_complete
);
  state_t state, next_state;
  logic [1:0] size, bus_size;
  logic accept, bad, done, expired, err_next;
  logic [31:0] rdata_next;
  assign accept = cmd_valid && cmd_ready;
  assign bad = bad_cmd(cmd_size, cmd_addr[1:0]);
  assign done = data_ready || expired;
  assign bus_size = accept ? cmd_size : size;
`ifdef TQV_BUS_INIT_TIMEOUT_EN
  tqv_bus_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .en(state == WRITE || state == READ),
    .expired(expired)
  );
`else
  assign expired = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif
  always_comb begin
    next_state = state;
    err_next = rsp_err;
    rdata_next = rsp_rdata;
    case (state)
      IDLE: if (accept) begin
        next_state = bad ? RESP : cmd_write ? WRITE : READ;
        err_next = bad;
        rdata_next = '0;
      end
      WRITE: if (done) begin
        next_state = RESP;
        err_next = !data_ready;
      end
      READ: if (done) begin
        next_state = COMPLETE;
        err_next = !data_ready;
        rdata_next = data_ready ? data_in & size_mask(size) : '0;
      end
      COMPLETE: next_state = RESP;
      RESP: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end
  // Outputs are registered from the next state so each one is glitch-free and aligned with state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      size <= SZ_NONE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
      addr_out <= '0;
      data_out <= '0;
      data_write_n <= SZ_NONE;
      data_read_n <= SZ_NONE;
      data_read_complete <= 1'b0;
    end else begin
      state <= next_state;
      cmd_ready <= next_state == IDLE;
      rsp_valid <= next_state == RESP;
      rsp_err <= err_next;
      rsp_rdata <= rdata_next;
      data_read_complete <= next_state == COMPLETE;
      data_write_n <= next_state == WRITE ? bus_size : SZ_NONE;
      data_read_n <= next_state == READ ? bus_size : SZ_NONE;
      if (accept && !bad) begin
        size <= cmd_size;
        addr_out <= cmd_addr;
        data_out <= cmd_wdata;
      end
    end
  end
endmodule

// File: tb/tb_tqv_bus_initiator.sv
// tb_tqv_bus_initiator: randomized bench checking the bus initiator against a timeline model
module tb_tqv_bus_initiator;
  localparam int TMO = 4;
`ifdef TQV_BUS_INIT_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [1:0] cmd_size = '0;
  logic [10:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [10:0] addr_out;
  logic [31:0] data_out, data_in = '0;
  logic [1:0] data_write_n, data_read_n;
  logic data_ready = 1'b0, data_read_complete;

  tqv_bus_initiator #(.TIMEOUT_CYCLES(TMO), .ADDR_W(11)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr_out(addr_out), .data_out(data_out), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_in(data_in), .data_ready(data_ready),
    .data_read_complete(data_read_complete)
  );

  always #5 clk = ~clk;

  int cyc = 0, errors = 0, checks = 0, idle_from = 1 << 30;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_q <= rst;
  end

  // Current transaction timeline: accepted at edge t_a, bus busy through t_a+t_lat,
  // response from edge t_r, idle again from edge t_fin.
  bit act = 1'b0, t_w, t_bad, t_err;
  logic [1:0] t_sz;
  logic [10:0] t_ad;
  logic [31:0] t_wd, t_exp;
  int t_lat, t_a, t_r, t_fin;
  int obs_off = -1, obs_cpl = 0;
  logic [31:0] obs_rdata = '0;
  logic obs_err = 1'b0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", n, cyc, a, e);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_q) begin
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_addr_out", addr_out, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_write_n", data_write_n, 3);
      chk("rst_read_n", data_read_n, 3);
      chk("rst_complete", data_read_complete, 0);
    end else if (!act || cyc < t_a || cyc >= t_fin) begin
      chk("idle_write_n", data_write_n, 3);
      chk("idle_read_n", data_read_n, 3);
      chk("idle_complete", data_read_complete, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_cmd_ready", cmd_ready, cyc >= idle_from);
    end else begin
      if (data_read_complete) obs_cpl++;
      if (rsp_valid && obs_off < 0) begin
        obs_off = cyc - t_a + 1;
        obs_rdata = rsp_rdata;
        obs_err = rsp_err;
      end
      chk("busy_cmd_ready", cmd_ready, 0);
      if (!t_bad && cyc <= t_a + t_lat) begin
        chk("req_write_n", data_write_n, t_w ? t_sz : 3);
        chk("req_read_n", data_read_n, t_w ? 3 : t_sz);
        chk("req_addr", addr_out, t_ad);
        if (t_w) chk("req_wdata", data_out, t_wd);
        chk("req_rsp_valid", rsp_valid, 0);
        chk("req_complete", data_read_complete, 0);
      end else begin
        chk("post_write_n", data_write_n, 3);
        chk("post_read_n", data_read_n, 3);
        chk("complete", data_read_complete, cyc < t_r);
        chk("rsp_valid", rsp_valid, cyc >= t_r);
        if (cyc >= t_r) begin
          chk("rsp_err", rsp_err, t_err);
          chk("rsp_rdata", rsp_rdata, t_exp);
        end
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    while (!cmd_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
  endtask

  // lat: cycles the request is visible before data_ready; nr: peripheral never answers
  task automatic run_txn(input bit w, input logic [1:0] sz, input logic [10:0] ad,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int lat, input int bp, input bit nr);
    wait_ready();
    t_w = w; t_sz = sz; t_ad = ad; t_wd = wd;
    t_bad = sz == 2'd3 || (int'(ad) % (1 << sz)) != 0;
    t_err = t_bad || nr;
    t_lat = nr ? TMO - 1 : lat;
    t_exp = (t_err || w) ? 32'd0 : rd & 32'((64'd1 << (8 << sz)) - 64'd1);
    t_a = cyc + 1;
    t_r = t_bad ? t_a : t_a + t_lat + (w ? 1 : 2);
    t_fin = t_r + bp + 1;
    obs_off = -1;
    obs_cpl = 0;
    act = 1'b1;
    for (int e = t_a - 1; e < t_fin; e++) begin
      cmd_valid = e == t_a - 1 ? 1'b1 : (e >= t_a ? 1'($urandom) : 1'b0);
      if (e == t_a - 1) {cmd_write, cmd_size, cmd_addr, cmd_wdata} = {w, sz, ad, wd};
      else {cmd_write, cmd_size, cmd_addr, cmd_wdata} = {1'($urandom), 2'($urandom), 11'($urandom), $urandom};
      data_ready = (!t_bad && e >= t_a && e <= t_a + t_lat) ? (e == t_a + t_lat && !nr) : 1'($urandom);
      data_in = e == t_a + t_lat ? rd : $urandom;
      rsp_ready = e < t_r ? 1'($urandom) : e == t_r + bp;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    data_ready = 1'b0;
    rsp_ready = 1'b0;
    act = 1'b0;
  endtask

  task automatic reset_abort();
    wait_ready();
    t_w = 1'b0; t_sz = 2'd2; t_ad = 11'h048; t_bad = 1'b0; t_err = 1'b0;
    t_lat = 1 << 30; t_a = cyc + 1; t_r = 1 << 30; t_fin = 1 << 30;
    obs_off = -1; obs_cpl = 0; act = 1'b1;
    {cmd_valid, cmd_write, cmd_size, cmd_addr} = {1'b1, 1'b0, 2'd2, 11'h048};
    data_ready = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    act = 1'b0;
    idle_from = cyc + 1;
    @(posedge clk); #1;
    chk("abort_no_complete", obs_cpl, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] ad;
    logic [1:0] sz;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_from = cyc + 1;
    run_txn(1'b1, 2'd0, 11'h040, 32'h0000_00A5, 32'h0, 0, 0, 1'b0);
    chk("lit_bw_off", obs_off, 2);
    chk("lit_bw_err", obs_err, 0);
    chk("lit_bw_rdata", obs_rdata, 0);
    run_txn(1'b0, 2'd2, 11'h044, 32'h0, 32'h1234_5678, 1, 0, 1'b0);
    chk("lit_wr_off", obs_off, 4);
    chk("lit_wr_cpl", obs_cpl, 1);
    chk("lit_wr_rdata", obs_rdata, 32'h1234_5678);
    run_txn(1'b0, 2'd0, 11'h045, 32'h0, 32'hDEAD_BEEF, 1, 0, 1'b0);
    chk("lit_br_rdata", obs_rdata, 32'h0000_00EF);
    run_txn(1'b0, 2'd1, 11'h046, 32'h0, 32'hDEAD_BEEF, 1, 0, 1'b0);
    chk("lit_hr_rdata", obs_rdata, 32'h0000_BEEF);
    run_txn(1'b1, 2'd3, 11'h040, 32'h55, 32'h0, 0, 1, 1'b0);
    chk("lit_sz3_off", obs_off, 1);
    chk("lit_sz3_err", obs_err, 1);
    run_txn(1'b0, 2'd2, 11'h042, 32'h0, 32'hFFFF_FFFF, 0, 0, 1'b0);
    chk("lit_mis_err", obs_err, 1);
    chk("lit_mis_cpl", obs_cpl, 0);
    chk("lit_mis_rdata", obs_rdata, 0);
    run_txn(1'b0, 2'd2, 11'h050, 32'h0, 32'hCAFE_F00D, 2, 5, 1'b0);
    chk("lit_bp_off", obs_off, 5);
    chk("lit_bp_rdata", obs_rdata, 32'hCAFE_F00D);
`ifdef TQV_BUS_INIT_TIMEOUT_EN
    run_txn(1'b0, 2'd2, 11'h060, 32'h0, 32'h1111_2222, 0, 2, 1'b1);
    chk("lit_to_rd_off", obs_off, TMO + 2);
    chk("lit_to_rd_err", obs_err, 1);
    chk("lit_to_rd_rdata", obs_rdata, 0);
    chk("lit_to_rd_cpl", obs_cpl, 1);
    run_txn(1'b1, 2'd1, 11'h062, 32'h3333, 32'h0, 0, 0, 1'b1);
    chk("lit_to_wr_off", obs_off, TMO + 1);
    chk("lit_to_wr_err", obs_err, 1);
`endif
    reset_abort();
    for (int i = 0; i < 300; i++) begin
      sz = $urandom_range(5) == 0 ? 2'd3 : 2'($urandom_range(2));
      ad = 11'($urandom);
      if ($urandom_range(3) != 0) ad[1:0] = 2'b00;
      run_txn(1'($urandom), sz, ad, $urandom, $urandom, $urandom_range(TMO_ON ? 3 : 6),
              $urandom_range(3), TMO_ON && $urandom_range(9) == 0);
    end
    reset_abort();
    run_txn(1'b0, 2'd1, 11'h07E, 32'h0, 32'h8765_4321, 0, 0, 1'b0);
    chk("lit_post_rst_rdata", obs_rdata, 32'h0000_4321);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
